// File: rtl/mult_pkg.sv
// Shared types and constants for the parametrised sequential multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_cond_neg.sv
// Conditional two's complement negation: out = en ? -in : in.
module mult_cond_neg #(
    parameter int N = 32
) (
    input  logic [N-1:0] in,
    input  logic         en,
    output logic [N-1:0] out
);

    assign out = en ? (~in + {{(N-1){1'b0}}, 1'b1}) : in;

endmodule

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier with per-operand sign mode and valid/ready
// handshakes; one exact 2*WIDTH-bit product per transaction.
module seq_mult_param
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               a_signed,
    input  logic               b_signed,
    output logic [2*WIDTH-1:0] out,
    output logic               out_valid,
    input  logic               out_ready
);

    state_e             state_q, state_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   ma_q, ma_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     acc_sum;
    logic [2*WIDTH:0]   acc_step;
    logic [2*WIDTH-1:0] prod_out;

    assign a_neg = a_signed & in_a[WIDTH-1];
    assign b_neg = b_signed & in_b[WIDTH-1];

    mult_cond_neg #(.N(WIDTH)) u_neg_a (.in(in_a), .en(a_neg), .out(a_mag));
    mult_cond_neg #(.N(WIDTH)) u_neg_b (.in(in_b), .en(b_neg), .out(b_mag));

    // Upper half is WIDTH+1 bits so the add never loses its carry before the shift.
    assign acc_sum  = acc_q[2*WIDTH:WIDTH] + {1'b0, (mb_q[0] ? ma_q : {WIDTH{1'b0}})};
    assign acc_step = {acc_sum, acc_q[WIDTH-1:0]} >> 1;

    mult_cond_neg #(.N(2*WIDTH)) u_neg_p (
        .in (acc_step[2*WIDTH-1:0]),
        .en (neg_q),
        .out(prod_out)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_ready_q && in_valid) begin
                    ma_d       = a_mag;
                    mb_d       = b_mag;
                    // A zero operand forces a positive result, never negative zero.
                    neg_d      = (a_neg ^ b_neg) & (|in_a) & (|in_b);
                    acc_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                acc_d = acc_step;
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    out_d       = prod_out;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed-vector bench for seq_mult_param at WIDTH = 32.
module tb_seq_mult_param;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          a_signed = 1'b0;
    logic          b_signed = 1'b0;
    logic [2*W-1:0] out;
    logic          out_valid;
    logic          out_ready = 1'b1;

    int nvec = 0;
    int nfail = 0;

    seq_mult_param #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .a_signed (a_signed),
        .b_signed (b_signed),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string         name;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          sa;
        logic          sb;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Present operands for one accept edge, then scramble them to prove they are not re-sampled.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic sa, input logic sb);
        int t = 0;
        @(negedge CLK);
        while (!in_ready && t < 100) begin
            @(negedge CLK);
            t++;
        end
        chk("accept_ready", {63'd0, in_ready}, 64'd1);
        in_a = a; in_b = b; a_signed = sa; b_signed = sb; in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; a_signed = ~sa; b_signed = ~sb;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        logic [2*W-1:0] held;

        vecs.push_back('{"u_30x90",      32'd30,        32'd90,        1'b0, 1'b0, 64'd2700});
        vecs.push_back('{"s_30xm90",     32'd30,        32'hFFFF_FFA6, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_F574});
        vecs.push_back('{"s_m30xm90",    32'hFFFF_FFE2, 32'hFFFF_FFA6, 1'b1, 1'b1, 64'd2700});
        vecs.push_back('{"u_max_sq",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001});
        vecs.push_back('{"s_min_sq",     32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000});
        vecs.push_back('{"m_m1xumax",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001});
        vecs.push_back('{"m_sminxumax",  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'h8000_0000_8000_0000});
        vecs.push_back('{"s_0xm5",       32'd0,         32'hFFFF_FFFB, 1'b1, 1'b1, 64'd0});
        vecs.push_back('{"s_m1x0",       32'hFFFF_FFFF, 32'd0,         1'b1, 1'b1, 64'd0});
        vecs.push_back('{"s_5x3",        32'd5,         32'd3,         1'b1, 1'b1, 64'd15});
        vecs.push_back('{"u_7x6",        32'd7,         32'd6,         1'b0, 1'b0, 64'd42});

        #2;
        chk("rst_in_ready",  {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out",       out, 64'd0);
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;
        repeat (2) @(negedge CLK);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        foreach (vecs[i]) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb);
            chk({vecs[i].name, "_busy"}, {63'd0, in_ready}, 64'd0);
            wait_valid(cyc);
            chk({vecs[i].name, "_latency"}, 64'(cyc), 64'd32);
            chk(vecs[i].name, out, vecs[i].exp);
            @(posedge CLK);
            #1;
            chk({vecs[i].name, "_drop"}, {62'd0, out_valid, in_ready}, 64'd1);
        end

        // Backpressure: hold the result for 10 cycles while poking in_valid.
        out_ready = 1'b0;
        accept(32'd1000, 32'd1000, 1'b0, 1'b0);
        wait_valid(cyc);
        chk("bp_out", out, 64'd1000000);
        held = out;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            in_valid = k[0];
            in_a = $urandom; in_b = $urandom;
            chk("bp_stall", {61'd0, out_valid, in_ready, 1'b0}, 64'd4);
            chk("bp_hold", out, held);
        end
        @(negedge CLK);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("bp_release", {62'd0, out_valid, in_ready}, 64'd1);
        repeat (40) @(posedge CLK);
        #1;
        chk("bp_no_queue", {62'd0, out_valid, in_ready}, 64'd1);

        // Reset mid-CALC: outputs clear immediately and the in-flight result never appears.
        accept(32'd123, 32'd456, 1'b0, 1'b0);
        repeat (14) @(posedge CLK);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_in_ready",  {63'd0, in_ready}, 64'd0);
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_out",       out, 64'd0);
        @(negedge CLK);
        reset_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (out_valid) cyc++;
        end
        chk("mid_rst_no_valid", 64'(cyc), 64'd0);
        accept(32'd7, 32'd6, 1'b0, 1'b0);
        wait_valid(cyc);
        chk("after_rst_latency", 64'(cyc), 64'd32);
        chk("after_rst_7x6", out, 64'd42);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
